// File: rtl/zeroriscy_rf_pkg.sv
// Shared definitions for the multi-port register file: address geometry
// derivation, the hard-wired zero register and an address qualifier.
package zeroriscy_rf_pkg;

    // Architectural register specifiers are always 5 bits wide
    localparam int unsigned RF_SPEC_BITS = 5;

    // x0 is hard-wired to zero
    localparam logic [RF_SPEC_BITS-1:0] REG_ZERO = 5'd0;

    // RV32E keeps 16 architectural registers, RV32I keeps 32
    function automatic int unsigned rf_addr_width(input int unsigned rv32e);
        return (rv32e != 0) ? 32'd4 : 32'd5;
    endfunction

    function automatic int unsigned rf_num_words(input int unsigned rv32e);
        return 32'd1 << rf_addr_width(rv32e);
    endfunction

    // True when the specifier names a real, writable register
    function automatic logic rf_addr_ok(input logic [RF_SPEC_BITS-1:0] addr,
                                        input int unsigned             rv32e);
        return (addr != REG_ZERO) && !((rv32e != 0) && addr[4]);
    endfunction

endpackage

// File: rtl/zeroriscy_rf_scoreboard.sv
// Pending-write scoreboard for long-latency (port B) destinations.
// Ports: clk/rst_n; raddr_i -> rbusy_o per read port; waddr_b_i/we_b_i clear
// a busy bit; rsv_addr_i/rsv_valid_i/rsv_ready_o reserve one; busy_cnt_o is
// the registered population of busy bits.
module zeroriscy_rf_scoreboard
    import zeroriscy_rf_pkg::*;
#(
    parameter int unsigned RV32E      = 0,
    parameter int unsigned NUM_RPORTS = 2,
    localparam int unsigned ADDR_WIDTH = rf_addr_width(RV32E)
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [NUM_RPORTS-1:0][RF_SPEC_BITS-1:0]   raddr_i,
    output logic [NUM_RPORTS-1:0]                     rbusy_o,
    input  logic [RF_SPEC_BITS-1:0]                   waddr_b_i,
    input  logic                                      we_b_i,
    input  logic [RF_SPEC_BITS-1:0]                   rsv_addr_i,
    input  logic                                      rsv_valid_i,
    output logic                                      rsv_ready_o,
    output logic [ADDR_WIDTH:0]                       busy_cnt_o
);

    localparam int unsigned NUM_WORDS = rf_num_words(RV32E);
    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

    logic [NUM_WORDS-1:0]  busy_q, busy_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] rsv_idx, clr_idx;
    logic                  rsv_ok, clr_ok, clr_hits_rsv;
    logic                  set_c, clr_c, inc_c, dec_c;

    assign rsv_idx      = rsv_addr_i[ADDR_WIDTH-1:0];
    assign clr_idx      = waddr_b_i[ADDR_WIDTH-1:0];
    assign rsv_ok       = rf_addr_ok(rsv_addr_i, RV32E);
    assign clr_ok       = rf_addr_ok(waddr_b_i, RV32E);
    assign clr_hits_rsv = we_b_i && (waddr_b_i == rsv_addr_i);

    // Stall a reservation only while its target is busy and not retiring now
    assign rsv_ready_o = !(rsv_ok && busy_q[rsv_idx] && !clr_hits_rsv);

    // Unqualified addresses (x0, upper half in RV32E) are accepted as no-ops
    assign set_c = rsv_valid_i && rsv_ready_o && rsv_ok;
    assign clr_c = we_b_i && clr_ok && busy_q[clr_idx];

    // Next busy vector and counter; a set wins over a same-address clear
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        inc_c  = 1'b0;
        dec_c  = 1'b0;
        if (clr_c) busy_d[clr_idx] = 1'b0;
        if (set_c) busy_d[rsv_idx] = 1'b1;
        busy_d[0] = 1'b0;
        inc_c = set_c && !busy_q[rsv_idx];
        dec_c = clr_c && !(set_c && (rsv_idx == clr_idx));
        if (inc_c && !dec_c && (cnt_q != CNT_WIDTH'(NUM_WORDS - 1))) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else if (dec_c && !inc_c && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Per-port busy lookup, no same-cycle forwarding
    always_comb begin
        rbusy_o = '0;
        for (int k = 0; k < int'(NUM_RPORTS); k++) begin
            rbusy_o[k] = rf_addr_ok(raddr_i[k], RV32E) &&
                         busy_q[raddr_i[k][ADDR_WIDTH-1:0]];
        end
    end

    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/zeroriscy_regfile_mp.sv
// Multi-read-port register file with two write ports and a reservation
// scoreboard for long-latency writebacks.
// Ports: clk/rst_n; test_en_i (unused); raddr_i/rdata_o/rbusy_o per read port;
// write port A (pipeline) and B (PPU/LSU); rsv_* reservation handshake;
// busy_cnt_o pending count; waw_err_o one-cycle A/B collision pulse.
module zeroriscy_regfile_mp
    import zeroriscy_rf_pkg::*;
#(
    parameter int unsigned RV32E        = 0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NUM_RPORTS   = 2,
    parameter int unsigned WRITE_BYPASS = 0,
    localparam int unsigned ADDR_WIDTH  = rf_addr_width(RV32E)
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    test_en_i,
    input  logic [NUM_RPORTS-1:0][RF_SPEC_BITS-1:0] raddr_i,
    output logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0]   rdata_o,
    output logic [NUM_RPORTS-1:0]                   rbusy_o,
    input  logic [RF_SPEC_BITS-1:0]                 waddr_a_i,
    input  logic [DATA_WIDTH-1:0]                   wdata_a_i,
    input  logic                                    we_a_i,
    input  logic [RF_SPEC_BITS-1:0]                 waddr_b_i,
    input  logic [DATA_WIDTH-1:0]                   wdata_b_i,
    input  logic                                    we_b_i,
    input  logic [RF_SPEC_BITS-1:0]                 rsv_addr_i,
    input  logic                                    rsv_valid_i,
    output logic                                    rsv_ready_o,
    output logic [ADDR_WIDTH:0]                     busy_cnt_o,
    output logic                                    waw_err_o
);

    localparam int unsigned NUM_WORDS = rf_num_words(RV32E);

    logic                  wa_en, wb_en;
    logic [ADDR_WIDTH-1:0] wa_idx, wb_idx;
    logic                  waw_err_q, waw_err_d;
    logic [DATA_WIDTH-1:0] rf_c [NUM_WORDS];
    logic                  unused_test_en;

    assign unused_test_en = test_en_i;

    // Writes to x0 or to nonexistent RV32E registers are dropped here
    assign wa_en  = we_a_i && rf_addr_ok(waddr_a_i, RV32E);
    assign wb_en  = we_b_i && rf_addr_ok(waddr_b_i, RV32E);
    assign wa_idx = waddr_a_i[ADDR_WIDTH-1:0];
    assign wb_idx = waddr_b_i[ADDR_WIDTH-1:0];

    // x0 has no storage
    assign rf_c[0] = '0;

    // One flop word per register; port A wins a same-address collision
    for (genvar i = 1; i < int'(NUM_WORDS); i++) begin : g_word
        logic [DATA_WIDTH-1:0] word_q, word_d;

        always_comb begin
            word_d = word_q;
            if (wa_en && (wa_idx == ADDR_WIDTH'(i))) begin
                word_d = wdata_a_i;
            end else if (wb_en && (wb_idx == ADDR_WIDTH'(i))) begin
                word_d = wdata_b_i;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) word_q <= '0;
            else        word_q <= word_d;
        end

        assign rf_c[i] = word_q;
    end

    assign waw_err_d = wa_en && wb_en && (waddr_a_i == waddr_b_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) waw_err_q <= 1'b0;
        else        waw_err_q <= waw_err_d;
    end

    assign waw_err_o = waw_err_q;

    // Combinational read muxes with optional same-cycle forwarding (A over B)
    always_comb begin
        rdata_o = '0;
        for (int k = 0; k < int'(NUM_RPORTS); k++) begin
            if (rf_addr_ok(raddr_i[k], RV32E)) begin
                rdata_o[k] = rf_c[raddr_i[k][ADDR_WIDTH-1:0]];
                if (WRITE_BYPASS != 0) begin
                    if (wb_en && (waddr_b_i == raddr_i[k])) rdata_o[k] = wdata_b_i;
                    if (wa_en && (waddr_a_i == raddr_i[k])) rdata_o[k] = wdata_a_i;
                end
            end
        end
    end

    zeroriscy_rf_scoreboard #(
        .RV32E      (RV32E),
        .NUM_RPORTS (NUM_RPORTS)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .raddr_i     (raddr_i),
        .rbusy_o     (rbusy_o),
        .waddr_b_i   (waddr_b_i),
        .we_b_i      (we_b_i),
        .rsv_addr_i  (rsv_addr_i),
        .rsv_valid_i (rsv_valid_i),
        .rsv_ready_o (rsv_ready_o),
        .busy_cnt_o  (busy_cnt_o)
    );

endmodule

// File: tb/tb_zeroriscy_regfile_mp.sv
// Bench for zeroriscy_regfile_mp: three configurations (default, write
// bypass, RV32E) share one stimulus stream; expectations are queued by the
// stimulus and consumed by a monitor on the falling clock edge.
module tb_zeroriscy_regfile_mp;

    localparam int K_RDATA = 0;
    localparam int K_RBUSY = 1;
    localparam int K_READY = 2;
    localparam int K_CNT   = 3;
    localparam int K_WAW   = 4;

    typedef struct {
        int          dut;
        int          kind;
        int          port;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             test_en;
    logic [1:0][4:0]  raddr;
    logic [4:0]       waddr_a, waddr_b, rsv_addr;
    logic [31:0]      wdata_a, wdata_b;
    logic             we_a, we_b, rsv_valid;

    logic [1:0][31:0] rdata0, rdata1, rdata2;
    logic [1:0]       rbusy0, rbusy1, rbusy2;
    logic             ready0, ready1, ready2;
    logic [5:0]       cnt0, cnt1;
    logic [4:0]       cnt2;
    logic             waw0, waw1, waw2;

    always #5 clk = ~clk;

    zeroriscy_regfile_mp #(.RV32E(0), .DATA_WIDTH(32), .NUM_RPORTS(2), .WRITE_BYPASS(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .test_en_i(test_en), .raddr_i(raddr), .rdata_o(rdata0),
        .rbusy_o(rbusy0), .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b), .rsv_addr_i(rsv_addr),
        .rsv_valid_i(rsv_valid), .rsv_ready_o(ready0), .busy_cnt_o(cnt0), .waw_err_o(waw0));

    zeroriscy_regfile_mp #(.RV32E(0), .DATA_WIDTH(32), .NUM_RPORTS(2), .WRITE_BYPASS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .test_en_i(test_en), .raddr_i(raddr), .rdata_o(rdata1),
        .rbusy_o(rbusy1), .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b), .rsv_addr_i(rsv_addr),
        .rsv_valid_i(rsv_valid), .rsv_ready_o(ready1), .busy_cnt_o(cnt1), .waw_err_o(waw1));

    zeroriscy_regfile_mp #(.RV32E(1), .DATA_WIDTH(32), .NUM_RPORTS(2), .WRITE_BYPASS(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .test_en_i(test_en), .raddr_i(raddr), .rdata_o(rdata2),
        .rbusy_o(rbusy2), .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b), .rsv_addr_i(rsv_addr),
        .rsv_valid_i(rsv_valid), .rsv_ready_o(ready2), .busy_cnt_o(cnt2), .waw_err_o(waw2));

    function automatic logic [31:0] sample(input int d, input int k, input int p);
        logic [31:0] v;
        v = 32'hDEAD_0000;
        case (d)
            0: case (k)
                K_RDATA: v = rdata0[p];
                K_RBUSY: v = 32'(rbusy0[p]);
                K_READY: v = 32'(ready0);
                K_CNT:   v = 32'(cnt0);
                default: v = 32'(waw0);
            endcase
            1: case (k)
                K_RDATA: v = rdata1[p];
                K_RBUSY: v = 32'(rbusy1[p]);
                K_READY: v = 32'(ready1);
                K_CNT:   v = 32'(cnt1);
                default: v = 32'(waw1);
            endcase
            default: case (k)
                K_RDATA: v = rdata2[p];
                K_RBUSY: v = 32'(rbusy2[p]);
                K_READY: v = 32'(ready2);
                K_CNT:   v = 32'(cnt2);
                default: v = 32'(waw2);
            endcase
        endcase
        return v;
    endfunction

    // Monitor: drain every expectation queued for the current cycle
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e   = sb_q.pop_front();
            act = sample(e.dut, e.kind, e.port);
            n_checks++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s dut%0d port%0d: got %h expected %h",
                         e.name, e.dut, e.port, act, e.exp);
            end
        end
    end

    task automatic expect_one(input int d, input int k, input int p,
                              input logic [31:0] v, input string name);
        exp_t e;
        e.dut = d; e.kind = k; e.port = p; e.exp = v; e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic expect_all(input int k, input int p, input logic [31:0] v,
                              input string name);
        for (int d = 0; d < 3; d++) expect_one(d, k, p, v, name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        raddr[0] = a0;
        raddr[1] = a1;
    endtask

    initial begin
        rst_n = 1'b0; test_en = 1'b0; raddr = '0;
        waddr_a = '0; wdata_a = '0; we_a = 1'b0;
        waddr_b = '0; wdata_b = '0; we_b = 1'b0;
        rsv_addr = '0; rsv_valid = 1'b0;
        step(); step();
        set_rd(5'd5, 5'd5);
        expect_all(K_CNT, 0, 0, "rst_cnt");
        expect_all(K_WAW, 0, 0, "rst_waw");
        expect_all(K_READY, 0, 1, "rst_ready");
        expect_all(K_RDATA, 0, 0, "rst_rdata");

        // Write x5 via A; bypass config sees it immediately
        step(); rst_n = 1'b1;
        we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'h1234_5678;
        expect_one(0, K_RDATA, 0, 32'h0, "nobyp_old");
        expect_one(2, K_RDATA, 0, 32'h0, "e_nobyp_old");
        expect_one(1, K_RDATA, 0, 32'h1234_5678, "byp_a_p0");
        expect_one(1, K_RDATA, 1, 32'h1234_5678, "byp_a_p1");

        step(); waddr_a = 5'd0; wdata_a = 32'hFFFF_FFFF;
        expect_all(K_RDATA, 0, 32'h1234_5678, "x5_p0");
        expect_all(K_RDATA, 1, 32'h1234_5678, "x5_p1");

        step(); we_a = 1'b0; set_rd(5'd0, 5'd5);
        expect_all(K_RDATA, 0, 32'h0, "x0_zero");
        expect_all(K_RDATA, 1, 32'h1234_5678, "x5_keep");

        // A/B collision on x7
        step(); we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'hAAAA_AAAA;
        we_b = 1'b1; waddr_b = 5'd7; wdata_b = 32'h5555_5555; set_rd(5'd7, 5'd7);
        expect_one(0, K_RDATA, 0, 32'h0, "waw_nobyp");
        expect_one(1, K_RDATA, 0, 32'hAAAA_AAAA, "waw_byp_a");
        expect_all(K_WAW, 0, 0, "waw_pre");

        step(); we_a = 1'b0; we_b = 1'b0;
        expect_all(K_RDATA, 0, 32'hAAAA_AAAA, "waw_data");
        expect_all(K_WAW, 0, 1, "waw_pulse");

        step();
        expect_all(K_WAW, 0, 0, "waw_drop");
        rsv_valid = 1'b1; rsv_addr = 5'd3; set_rd(5'd3, 5'd3);
        expect_all(K_READY, 0, 1, "rsv3_ready");
        expect_all(K_RBUSY, 0, 0, "rsv3_pre_busy");
        expect_all(K_CNT, 0, 0, "rsv3_pre_cnt");

        step();
        expect_all(K_READY, 0, 0, "rsv3_again_stall");
        expect_all(K_RBUSY, 0, 1, "rsv3_busy_p0");
        expect_all(K_RBUSY, 1, 1, "rsv3_busy_p1");
        expect_all(K_CNT, 0, 1, "rsv3_cnt");

        // Retire x3 while re-reserving it
        step(); we_b = 1'b1; waddr_b = 5'd3; wdata_b = 32'h33;
        expect_all(K_READY, 0, 1, "clr_set_ready");
        expect_all(K_RBUSY, 0, 1, "clr_set_nofwd");
        expect_all(K_CNT, 0, 1, "clr_set_cnt_pre");

        step(); rsv_valid = 1'b0; we_b = 1'b0;
        expect_all(K_RBUSY, 0, 1, "clr_set_busy");
        expect_all(K_CNT, 0, 1, "clr_set_cnt");
        expect_all(K_READY, 0, 0, "clr_set_stall");
        expect_all(K_RDATA, 0, 32'h33, "clr_set_data");

        step(); we_b = 1'b1; wdata_b = 32'h44;
        expect_all(K_CNT, 0, 1, "clr_cnt_pre");

        step(); we_b = 1'b0;
        expect_all(K_CNT, 0, 0, "clr_cnt");
        expect_all(K_RBUSY, 0, 0, "clr_busy");
        expect_all(K_READY, 0, 1, "clr_ready");
        expect_all(K_RDATA, 0, 32'h44, "clr_data");

        // B write to a non-busy register
        step(); we_b = 1'b1; waddr_b = 5'd8; wdata_b = 32'h88; set_rd(5'd8, 5'd8);
        expect_one(0, K_RDATA, 0, 32'h0, "b_nobyp");
        expect_one(1, K_RDATA, 0, 32'h88, "b_byp");

        step(); we_b = 1'b0;
        expect_all(K_RDATA, 0, 32'h88, "b_free_data");
        expect_all(K_RBUSY, 0, 0, "b_free_busy");
        expect_all(K_CNT, 0, 0, "b_free_cnt");

        // A write must not clear a reservation
        step(); rsv_valid = 1'b1; rsv_addr = 5'd10; set_rd(5'd10, 5'd10);
        expect_all(K_READY, 0, 1, "rsv10_ready");

        step(); rsv_valid = 1'b0; we_a = 1'b1; waddr_a = 5'd10; wdata_a = 32'h1010;
        expect_all(K_CNT, 0, 1, "rsv10_cnt");

        step(); we_a = 1'b0;
        expect_all(K_RBUSY, 0, 1, "a_keeps_busy");
        expect_all(K_CNT, 0, 1, "a_keeps_cnt");
        expect_all(K_RDATA, 0, 32'h1010, "a_data");

        // Upper-half addresses in RV32E
        step(); we_a = 1'b1; waddr_a = 5'd20; wdata_a = 32'h1; set_rd(5'd20, 5'd4);
        expect_one(1, K_RDATA, 0, 32'h1, "x20_byp");

        step(); we_a = 1'b0;
        expect_one(0, K_RDATA, 0, 32'h1, "x20_i");
        expect_one(2, K_RDATA, 0, 32'h0, "x20_e");
        expect_one(2, K_RDATA, 1, 32'h0, "x4_e");
        expect_one(2, K_RBUSY, 0, 32'h0, "x20_e_busy");

        step(); rsv_valid = 1'b1; rsv_addr = 5'd20;
        expect_all(K_READY, 0, 1, "rsv20_ready");

        step(); rsv_addr = 5'd5;
        expect_all(K_READY, 0, 1, "rsv5_ready");
        expect_one(0, K_CNT, 0, 32'd2, "cnt_i_2");
        expect_one(2, K_CNT, 0, 32'd1, "cnt_e_1");

        step(); rsv_addr = 5'd6;
        expect_one(0, K_CNT, 0, 32'd3, "cnt_i_3");
        expect_one(2, K_CNT, 0, 32'd2, "cnt_e_2");

        step(); rsv_valid = 1'b0; set_rd(5'd5, 5'd6);
        expect_one(0, K_CNT, 0, 32'd4, "cnt_i_4");
        expect_one(1, K_CNT, 0, 32'd4, "cnt_byp_4");
        expect_one(2, K_CNT, 0, 32'd3, "cnt_e_3");
        expect_all(K_RBUSY, 0, 1, "x5_busy");
        expect_all(K_RBUSY, 1, 1, "x6_busy");

        // Asynchronous reset in the middle of a cycle
        step(); rst_n = 1'b0;
        expect_all(K_CNT, 0, 0, "arst_cnt");
        expect_all(K_RBUSY, 0, 0, "arst_busy_p0");
        expect_all(K_RBUSY, 1, 0, "arst_busy_p1");
        expect_all(K_WAW, 0, 0, "arst_waw");
        expect_all(K_RDATA, 0, 32'h0, "arst_data");

        step(); rst_n = 1'b1; rsv_addr = 5'd5; set_rd(5'd10, 5'd20);
        expect_all(K_READY, 0, 1, "post_rst_ready5");
        expect_all(K_RBUSY, 0, 0, "post_rst_busy10");

        step(); rsv_addr = 5'd10;
        expect_all(K_READY, 0, 1, "post_rst_ready10");

        step(); step();
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/zeroriscy_regfile_mp.md
ZERORISCY_REGFILE_MP -- requirements
Module: zeroriscy_regfile_mp

Interface
REQ-001 SHALL have parameter RV32E, default 0: 1 gives 16 registers (ADDR_WIDTH 4), 0 gives 32 (ADDR_WIDTH 5).
REQ-002 SHALL have parameter DATA_WIDTH, default 32: register width.
REQ-003 SHALL have parameter NUM_RPORTS, default 2, legal 1..4: number of read ports.
REQ-004 SHALL have parameter WRITE_BYPASS, default 0: 1 forwards same-cycle write data to reads.
REQ-005 SHALL have ports: clk in 1 clock; rst_n in 1 reset, asynchronous, active-low.
REQ-006 SHALL have ports: test_en_i in 1, test mode, functionally unused.
REQ-007 SHALL have ports: raddr_i in NUM_RPORTS x 5, read addresses; rdata_o out NUM_RPORTS x DATA_WIDTH, read data; rbusy_o out NUM_RPORTS, addressed register pending.
REQ-008 SHALL have ports: waddr_a_i in 5, wdata_a_i in DATA_WIDTH, we_a_i in 1: pipeline writeback port A.
REQ-009 SHALL have ports: waddr_b_i in 5, wdata_b_i in DATA_WIDTH, we_b_i in 1: long-latency (PPU/LSU) writeback port B.
REQ-010 SHALL have ports: rsv_addr_i in 5, rsv_valid_i in 1, rsv_ready_o out 1: reservation handshake for port B destinations.
REQ-011 SHALL have ports: busy_cnt_o out ADDR_WIDTH+1, number of pending registers; waw_err_o out 1, registered collision pulse.

Function
REQ-012 Register 0 SHALL read as 0; writes and reservations to it SHALL have no effect.
REQ-013 With RV32E=1, addresses with bit 4 set SHALL read 0 with rbusy 0, and writes to them SHALL be ignored; reservations to them SHALL be accepted with no effect.
REQ-014 Reads SHALL be combinational: rdata_o[k] = register[raddr_i[k]], zero latency.
REQ-015 Writes SHALL update the register at the rising edge where the write enable is high, visible to reads the following cycle.
REQ-016 If A and B write the same nonzero address in one cycle, A's data SHALL be stored and waw_err_o SHALL pulse high for exactly one cycle, the next cycle.
REQ-017 With WRITE_BYPASS=1, a read matching an active write address SHALL return that write data, A over B; with 0, it SHALL return the stored value.
REQ-018 Scoreboard: a busy bit per register, set at the edge where rsv_valid_i and rsv_ready_o are both high; cleared at the edge where we_b_i is high for that address.
REQ-019 rsv_ready_o SHALL be combinational: high unless busy[rsv_addr_i] is set and not being cleared by port B this cycle.
REQ-020 Same-cycle set and clear of one address SHALL leave busy set.
REQ-021 A port B write to a non-busy register SHALL still update data; busy stays 0.
REQ-022 A port A write SHALL NOT alter busy bits.
REQ-023 rbusy_o[k] SHALL be busy[raddr_i[k]], without forwarding of same-cycle set or clear.
REQ-024 busy_cnt_o SHALL be a registered counter equal to the population of busy bits, updated by +1, -1 or 0 each cycle, never wrapping.

Reset
REQ-025 On rst_n low, asynchronously: all registers 0, all busy bits 0, busy_cnt_o 0, waw_err_o 0.
REQ-026 Reset mid-operation SHALL discard pending reservations; after release, rsv_ready_o SHALL be 1 for any address.

Structure
REQ-027 Package zeroriscy_rf_pkg SHALL hold the ADDR_WIDTH/NUM_WORDS derivation function and the register-0 constant.
REQ-028 The busy bits, reservation handshake and counter SHALL be a sub-module zeroriscy_rf_scoreboard; data storage and read muxing stay in the top.
REQ-029 Storage SHALL be flip-flops with no latches; register 0 SHALL have no storage.

Verification
REQ-030 Write A x5=0x1234_5678, then read x5 on all ports next cycle -> 0x1234_5678; write x0=0xFFFF_FFFF -> x0 reads 0.
REQ-031 Same cycle A x7=0xAAAA_AAAA, B x7=0x5555_5555 -> x7=0xAAAA_AAAA, waw_err_o high one cycle only.
REQ-032 Reserve x3 -> busy_cnt_o=1, rbusy for x3=1; re-reserve x3 -> rsv_ready_o=0; B write x3 with simultaneous re-reserve -> x3 stays busy, busy_cnt_o=1.
REQ-033 WRITE_BYPASS=1, A writes x9=0xDEAD_BEEF while reading x9 -> same-cycle rdata=0xDEAD_BEEF; with WRITE_BYPASS=0 -> old value.
REQ-034 RV32E=1: write x20=0x1 -> x20 and x4 read 0; reserve x5, x6, then assert rst_n low mid-cycle -> busy_cnt_o=0 and all rbusy 0 immediately.
